// File: rtl/perf_pkg.sv
// perf_pkg: shared types and register map for the performance-counter CSR block
package perf_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} perf_state_t;
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_CYC_LO = 3'd1;
  localparam logic [2:0] REG_CYC_HI = 3'd2;
  localparam logic [2:0] REG_CHG_LO = 3'd3;
  localparam logic [2:0] REG_CHG_HI = 3'd4;
  localparam logic [2:0] REG_FINAL  = 3'd5;
  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_CLEAR = 2;
endpackage

// File: rtl/sat_counter32.sv
// sat_counter32: 32-bit saturating counter with sticky overflow and synchronous clear
module sat_counter32
  import perf_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] count,
  output logic        ovf
);
  // clear beats increment; an increment at all-ones leaves count and flags overflow
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (&count) ovf <= 1'b1;
      else count <= count + 32'd1;
    end
endmodule

// File: rtl/perf_csr.sv
// perf_csr: bus-mapped cycle / PC-change counters with start, stop, clear and final-PC auto-stop
module perf_csr
  import perf_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter logic [15:0] FINAL_PC  = 16'hFFFF
) (
  input  logic        cpu_clk,
  input  logic        resetN,
  input  logic [15:0] pc,
  input  logic [15:0] addr,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        rd_en,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        running,
  output logic        finished
);
  perf_state_t state;
  logic [15:0] rel, prev_pc, final_reg, cyc_shadow, chg_shadow, rd_mux;
  logic [31:0] cyc, chg;
  logic [2:0]  off;
  logic        hit, rd_hit, wr_ctrl, clear, stop, start, cyc_ovf, chg_ovf;
  // window decode relative to the base, so the window may sit anywhere in the map
  assign rel     = addr - BASE_ADDR;
  assign hit     = rel < 16'd8;
  assign off     = rel[2:0];
  assign rd_hit  = rd_en & hit;
  assign wr_ctrl = wr_en & hit & (off == REG_CTRL);
  // only the highest-priority control bit acts: CLEAR > STOP > START
  assign clear   = wr_ctrl & wr_data[CTRL_CLEAR];
  assign stop    = wr_ctrl & ~wr_data[CTRL_CLEAR] & wr_data[CTRL_STOP];
  assign start   = wr_ctrl & ~wr_data[CTRL_CLEAR] & ~wr_data[CTRL_STOP] & wr_data[CTRL_START];
  assign running  = state == RUN;
  assign finished = state == DONE;
  sat_counter32 u_cyc (
    .clk(cpu_clk), .resetN(resetN), .clr(clear), .inc(state == RUN),
    .count(cyc), .ovf(cyc_ovf)
  );
  sat_counter32 u_chg (
    .clk(cpu_clk), .resetN(resetN), .clr(clear), .inc(state == RUN && pc != prev_pc),
    .count(chg), .ovf(chg_ovf)
  );
  // run-control FSM; STOP is checked before the final-PC match so it wins a tie
  always_ff @(posedge cpu_clk or negedge resetN)
    if (!resetN) state <= IDLE;
    else if (clear) state <= IDLE;
    else if (state == RUN && stop) state <= IDLE;
    else if (state == IDLE && start) state <= RUN;
    else if (state == RUN && pc == final_reg) state <= DONE;
  // previous PC tracked every cycle so the first RUN cycle compares against real history
  always_ff @(posedge cpu_clk or negedge resetN)
    if (!resetN) prev_pc <= '0;
    else prev_pc <= pc;
  // FINAL compare register, software writable
  always_ff @(posedge cpu_clk or negedge resetN)
    if (!resetN) final_reg <= FINAL_PC;
    else if (wr_en && hit && off == REG_FINAL) final_reg <= wr_data;
  // LO reads latch the matching HI half so a LO/HI pair reads one coherent 32-bit value
  always_ff @(posedge cpu_clk or negedge resetN)
    if (!resetN) begin
      cyc_shadow <= '0;
      chg_shadow <= '0;
    end else if (clear) begin
      cyc_shadow <= '0;
      chg_shadow <= '0;
    end else if (rd_hit) begin
      if (off == REG_CYC_LO) cyc_shadow <= cyc[31:16];
      if (off == REG_CHG_LO) chg_shadow <= chg[31:16];
    end
  // read mux sees pre-edge values, so reads colliding with writes return old data
  always_comb begin
    rd_mux = '0;
    case (off)
      REG_CTRL:   rd_mux = {12'b0, cyc_ovf | chg_ovf, finished, running, 1'b0};
      REG_CYC_LO: rd_mux = cyc[15:0];
      REG_CYC_HI: rd_mux = cyc_shadow;
      REG_CHG_LO: rd_mux = chg[15:0];
      REG_CHG_HI: rd_mux = chg_shadow;
      REG_FINAL:  rd_mux = final_reg;
      default:    rd_mux = '0;
    endcase
  end
  // registered read port; data holds between reads
  always_ff @(posedge cpu_clk or negedge resetN)
    if (!resetN) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_hit;
      if (rd_hit) rd_data <= rd_mux;
    end
endmodule
